// File: rtl/ifid_queue.sv
// Fetch/decode decoupling queue: holds instruction, PC, PC+4 and prediction bit per entry,
// flushes on redirect or debug, and halts the front end once an ECALL is dequeued.
module ifid_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_pc_plus4,
    input  logic                       in_pred_taken,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_plus4,
    output logic                       out_pred_taken,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic                       debug,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int          PW    = $clog2(DEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [31:0] ECALL = 32'h00000073;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] pc4_mem   [DEPTH];
    logic        pred_mem  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted_q, halted_d;
    logic          push, pop, clear;

    assign clear     = flush | debug;
    assign in_ready  = (count_q < CW'(DEPTH)) & ~halted_q & ~debug & ~flush;
    assign out_valid = (count_q != '0) & ~halted_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~clear;

    assign out_instr      = out_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign out_pc         = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign out_pc_plus4   = out_valid ? pc4_mem[rd_ptr_q]   : 32'h0;
    assign out_pred_taken = out_valid ? pred_mem[rd_ptr_q]  : 1'b0;

    assign halted = halted_q;
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // The ECALL is still handed to decode; halting takes effect after this edge.
        if (pop && (instr_mem[rd_ptr_q] == ECALL)) halted_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset; only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
            pc4_mem[wr_ptr_q]   <= in_pc_plus4;
            pred_mem[wr_ptr_q]  <= in_pred_taken;
        end
    end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Decoupling buffer between instruction fetch and decode. It holds up to DEPTH fetched instructions, together with each one's PC, PC+4 and branch-prediction bit.
- Absorbs decode stalls without stopping fetch mid-cycle, and discards all in-flight entries on a branch mispredict or jump redirect.
- Detects ECALL at the dequeue point and halts the front end.
- Its in_ready output is the fetch stage's PC enable.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction presented on the output when no valid entry exists (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_instr  input  32  fetched instruction.
- in_pc  input  32  PC of in_instr.
- in_pc_plus4  input  32  in_pc + 4.
- in_pred_taken  input  1  BTB predicted taken for in_instr.
- in_ready  output  1  queue accepts an entry this cycle; drives the fetch PC enable.
- out_valid  output  1  head entry valid for decode.
- out_instr  output  32  head instruction, or NOP_INSTR when empty.
- out_pc  output  32  head PC, or 0 when empty.
- out_pc_plus4  output  32  head PC+4, or 0 when empty.
- out_pred_taken  output  1  head prediction, or 0 when empty.
- out_ready  input  1  decode consumes the head this cycle (not stalled).
- flush  input  1  mispredict or jump redirect; discard all entries.
- debug  input  1  bootloader active; front end held idle.
- halted  output  1  ECALL (32'h00000073) has been dequeued.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous assert): count=0, read/write pointers=0, halted=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=0, out_pred_taken=0. Entry storage contents do not matter after reset.
- in_ready = (count < DEPTH) and not halted and not debug and not flush. It is combinational and does not depend on out_ready (no pass-through when full).
- Push: occurs when in_valid and in_ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (wraps).
- Pop: occurs when out_valid and out_ready. rd_ptr increments modulo DEPTH.
- out_valid = (count != 0) and not halted. Output fields are read combinationally from the entry at rd_ptr when out_valid, otherwise they take the empty values listed above.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any occupancy from 1 to DEPTH-1.
- Full (count=DEPTH): in_ready=0. A pop in that cycle frees a slot; the push is accepted the following cycle.
- Empty: out_valid=0. out_ready is ignored.
- flush has priority over push and pop. On the next edge, count=0 and both pointers=0. Any push or pop in the flush cycle is discarded. out_valid=0 from the cycle after flush.
- debug=1: no pushes. Existing entries are cleared on the next edge, exactly as for flush. Pops are suppressed while debug is high.
- ECALL: if a pop dequeues out_instr==32'h00000073, halted is set on that edge.
  - While halted: out_valid=0 and in_ready=0. Entries are frozen; flush still clears them.
  - halted clears only on rst.
  - The ECALL itself is delivered to decode (out_valid=1 in the popping cycle).
- Reset asserted mid-operation: all state returns to reset values immediately. Any entry accepted before the reset is lost.
- count never exceeds DEPTH and never underflows. A pop attempted while empty is a no-op.

Test Plan:
- Reset, then push instr 0x00500093 at pc 0x0 with out_ready=0 -> next cycle out_valid=1, out_instr=0x00500093, out_pc=0, out_pc_plus4=4, count=1.
- Hold out_ready=0 and push 2 entries (pc 0x0, 0x4) -> count=2, in_ready=0. Raise out_ready with in_valid=1 -> pop pc 0x0 with no push. Next cycle push pc 0x8 is accepted.
- Run continuous push and pop for 10 cycles, pc 0x0..0x24 -> out_pc follows input with 1-cycle lag, count stays 1, pointers wrap with no loss.
- Fill the queue, then assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, out_instr=0x13. The flushed pc does not appear.
- Push 0x00000073 at pc 0x10, then 0x00100093, with out_ready=1 -> ECALL is delivered once and halted=1. Then out_valid=0, in_ready=0, and the second instruction is never output until rst.
- Assert debug with 1 entry held -> in_ready=0 and count=0 the next cycle. Deassert debug -> normal push resumes.
